alu_div_seq: RTL

Sequential restoring divider that implements the MIPS DIV and DIVU operations. It is the inverse of the ALU's MUL path. It sits beside the ALU and takes the same 32-bit A/B operands. It returns the quotient (LO) and remainder (HI) after a fixed latency, using a start/busy/done handshake so the datapath can stall while it runs.

---
 rtl/alu_div_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU: quotient goes to LO and remainder to HI.
// Fixed latency of WIDTH+1 edges from the accept edge, with a start/busy/done handshake.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE. busy is high from the accept edge
  // until the completion edge. done is a one-cycle pulse on that completion edge,
  // and the results stay valid and held until the next completion.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_orig;
  logic             q_neg;
  logic             r_neg;
  logic             dz_r;
  logic             ov_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] min_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_mag   = (signed_op && A[WIDTH-1]) ? -A : A;
  assign b_mag   = (signed_op && B[WIDTH-1]) ? -B : B;

  // The partial remainder is always below the divisor, so WIDTH+1 bits hold the shifted value.
  assign shifted = {prem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  assign q_fin = q_neg ? -dvd : dvd;
  assign r_fin = r_neg ? -prem : prem;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      a_orig      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= a_mag;
            dvs    <= b_mag;
            a_orig <= A;
            q_neg  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg  <= signed_op & A[WIDTH-1];
            dz_r   <= (B == '0);
            ov_r   <= signed_op && (A == min_neg) && (B == '1);
            prem   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero results are fixed values rather than whatever the iteration produced.
          quotient    <= dz_r ? '1 : q_fin;
          remainder   <= dz_r ? a_orig : r_fin;
          div_by_zero <= dz_r;
          overflow    <= ov_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
